next_pc_ctrl: RTL

NEXT_PC_CTRL -- requirements
Module: next_pc_ctrl

---
 rtl/next_pc_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/next_pc_ctrl.sv
// Next-PC selection for a simple in-order core.
// Picks the PC register D input from reset, stall, interrupt entry,
// return-from-interrupt, subroutine return/call, jump, branch or the
// sequential increment, and tracks the interrupt return PC and the
// return-address storage.
// Optional feature macro: RAS_EN
//   defined   -> RAS_DEPTH-entry circular return stack (overflow overwrites oldest)
//   undefined -> single link register with a valid bit
`ifndef ISIZE
`define ISIZE 16
`endif

module next_pc_ctrl #(
  parameter logic [`ISIZE-1:0] IRQ_VECTOR = 'h0010,
  parameter int unsigned       RAS_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`ISIZE-1:0] curr_pc,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [`ISIZE-1:0] branch_target,
  input  logic              jump,
  input  logic [`ISIZE-1:0] jump_target,
  input  logic              call,
  input  logic [`ISIZE-1:0] call_target,
  input  logic              ret,
  input  logic              irq_req,
  input  logic              reti,
  output logic [`ISIZE-1:0] next_pc,
  output logic              flush,
  output logic              irq_ack,
  output logic              ras_err
);

  typedef enum logic {RUN, ISR} state_t;

  state_t            state, state_next;
  logic [`ISIZE-1:0] epc;
  logic [`ISIZE-1:0] inc_pc;
  logic [`ISIZE-1:0] lower_pc;
  logic              redirect;
  logic              push_req, pop_req, underflow_req, leave_isr;
  logic              irq_take;
  logic              advance;
  logic              do_push, do_pop;
  logic              stack_empty;
  logic              overflow;
  logic [`ISIZE-1:0] stack_top;

  if (RAS_DEPTH == 0) begin : g_bad_depth
    $error("next_pc_ctrl: RAS_DEPTH must be at least 1");
  end

  assign inc_pc   = curr_pc + `ISIZE'(1);
  assign irq_take = (state == RUN) && irq_req;
  assign advance  = !rst && !stall;
  assign do_push  = advance && push_req;
  assign do_pop   = advance && pop_req;

  // Everything below interrupt entry: also the value captured into epc on entry.
  always_comb begin
    lower_pc      = inc_pc;
    redirect      = 1'b0;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    underflow_req = 1'b0;
    leave_isr     = 1'b0;
    if ((state == ISR) && reti) begin
      lower_pc  = epc;
      redirect  = 1'b1;
      leave_isr = 1'b1;
    end else if (ret) begin
      // ret wins over a simultaneous call; the call is simply dropped
      if (!stack_empty) begin
        lower_pc = stack_top;
        redirect = 1'b1;
        pop_req  = 1'b1;
      end else begin
        underflow_req = 1'b1;
      end
    end else if (call) begin
      lower_pc = call_target;
      redirect = 1'b1;
      push_req = 1'b1;
    end else if (jump) begin
      lower_pc = jump_target;
      redirect = 1'b1;
    end else if (branch_taken) begin
      lower_pc = branch_target;
      redirect = 1'b1;
    end
  end

  // Final PC mux, flush and FSM next state.
  // On interrupt entry the lower-priority action still completes (its stack
  // effect included) so that epc resumes exactly where execution would have gone.
  always_comb begin
    next_pc    = lower_pc;
    flush      = redirect && (lower_pc != inc_pc);
    state_next = state;
    if (rst) begin
      next_pc    = '0;
      flush      = 1'b0;
      state_next = RUN;
    end else if (stall) begin
      next_pc = curr_pc;
      flush   = 1'b0;
    end else if (irq_take) begin
      next_pc    = IRQ_VECTOR;
      flush      = (IRQ_VECTOR != inc_pc);
      state_next = ISR;
    end else if (leave_isr) begin
      state_next = RUN;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Interrupt return PC, captured on entry.
  always_ff @(posedge clk) begin
    if (rst)                       epc <= '0;
    else if (advance && irq_take)  epc <= lower_pc;
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_ack <= 1'b0;
      ras_err <= 1'b0;
    end else begin
      irq_ack <= advance && irq_take;
      ras_err <= advance && (underflow_req || (push_req && overflow));
    end
  end

`ifdef RAS_EN
  localparam int unsigned      PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned      CW   = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0]    LAST = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0]    FULL = CW'(RAS_DEPTH);

  logic [`ISIZE-1:0] stack_mem [RAS_DEPTH];
  logic [PW-1:0]     wr_ptr, top_ptr;
  logic [CW-1:0]     count;
  logic              stack_full;

  assign top_ptr     = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
  assign stack_empty = (count == '0);
  assign stack_full  = (count == FULL);
  assign stack_top   = stack_mem[top_ptr];
  assign overflow    = stack_full;

  // Circular pointer and occupancy; a push when full overwrites the oldest slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      if (!stack_full) count <= count + CW'(1);
    end else if (do_pop) begin
      wr_ptr <= top_ptr;
      count  <= count - CW'(1);
    end
  end

  // Stack storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_ptr] <= inc_pc;
  end
`else
  logic [`ISIZE-1:0] link;
  logic              link_valid;

  assign stack_empty = !link_valid;
  assign stack_top   = link;
  assign overflow    = 1'b0;

  // Single link register: push overwrites, pop invalidates.
  always_ff @(posedge clk) begin
    if (rst) begin
      link       <= '0;
      link_valid <= 1'b0;
    end else if (do_push) begin
      link       <= inc_pc;
      link_valid <= 1'b1;
    end else if (do_pop) begin
      link_valid <= 1'b0;
    end
  end
`endif

endmodule
